// File: rtl/scoreboard_hazard_unit_if.sv
// D-stage hazard bundle between the datapath (master) and the hazard unit (slave).
// Carries operand/destination info in, and stall/flush enables plus debug state out.
interface scoreboard_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 3
);
  logic [REG_AW-1:0]      rsD;
  logic [REG_AW-1:0]      rtD;
  logic                   useRsD;
  logic                   useRtD;
  logic                   branchD;
  logic                   regwriteD;
  logic [REG_AW-1:0]      writeregD;
  logic [LAT_W-1:0]       latD;
  logic                   mduD;
  logic                   flush_req;

  logic                   stallF;
  logic                   stallD;
  logic                   stallE;
  logic                   flushD;
  logic                   flushE;
  logic                   flushM;
  logic                   mdu_busy;
  logic [(1<<REG_AW)-1:0] pending;

  modport master (
    output rsD, rtD, useRsD, useRtD, branchD, regwriteD, writeregD, latD, mduD, flush_req,
    input  stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy, pending
  );

  modport slave (
    input  rsD, rtD, useRsD, useRtD, branchD, regwriteD, writeregD, latD, mduD, flush_req,
    output stallF, stallD, stallE, flushD, flushE, flushM, mdu_busy, pending
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register countdown scoreboard hazard unit with a multi-cycle MDU occupancy
// counter and an exception flush path; drives every pipeline stall/flush enable.
module scoreboard_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int LAT_W      = 3,
  parameter int MDU_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  scoreboard_hazard_unit_if.slave hz
);

  localparam int NREG  = 1 << REG_AW;
  localparam int MDU_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [MDU_W-1:0] MDU_INIT = MDU_W'(MDU_CYCLES - 1);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [MDU_W-1:0] mdu_cnt_q;
  logic [MDU_W-1:0] mdu_cnt_d;

  logic rs_ok;
  logic rt_ok;
  logic datastall;
  logic mdustall;
  logic issue;

  // Branches read operands in D and need the result already available;
  // everything else reads in E, so a count of 1 is forwarded just in time.
  function automatic logic src_ok(input logic [REG_AW-1:0] r,
                                  input logic              use_r,
                                  input logic              br,
                                  input logic [LAT_W-1:0]  c);
    if (!use_r || (r == '0)) return 1'b1;
    if (br)                  return (c == '0);
    return (c <= LAT_W'(1));
  endfunction

  always_comb begin
    rs_ok     = src_ok(hz.rsD, hz.useRsD, hz.branchD, cnt_q[hz.rsD]);
    rt_ok     = src_ok(hz.rtD, hz.useRtD, hz.branchD, cnt_q[hz.rtD]);
    datastall = !rs_ok || !rt_ok;
    mdustall  = (mdu_cnt_q != '0);
  end

  // Flush overrides everything; a frozen E stage is never bubbled.
  always_comb begin
    if (hz.flush_req) begin
      hz.stallF = 1'b0;
      hz.stallD = 1'b0;
      hz.stallE = 1'b0;
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushM = 1'b1;
    end else begin
      hz.stallF = datastall || mdustall;
      hz.stallD = datastall || mdustall;
      hz.stallE = mdustall;
      hz.flushD = 1'b0;
      hz.flushE = datastall && !mdustall;
      hz.flushM = mdustall;
    end
    hz.mdu_busy = mdustall;
    issue       = !(datastall || mdustall) && !hz.flush_req;
  end

  always_comb begin
    hz.pending = '0;
    for (int i = 1; i < NREG; i++) begin
      hz.pending[i] = (cnt_q[i] != '0);
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default on
  // entry so no path leaves it unassigned and infers a latch.
  always_comb begin
    cnt_d     = cnt_q;
    mdu_cnt_d = mdu_cnt_q;
    if (hz.flush_req) begin
      for (int i = 0; i < NREG; i++) cnt_d[i] = '0;
      mdu_cnt_d = '0;
    end else if (mdustall) begin
      mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
      // A new write to the same register supersedes its decrement.
      if (issue && hz.regwriteD && (hz.writeregD != '0) && (hz.latD != '0)) begin
        cnt_d[hz.writeregD] = hz.latD;
      end
      if (issue && hz.mduD) mdu_cnt_d = MDU_INIT;
    end
    cnt_d[0] = '0;
  end

  // NOTE: the scoreboard array is reset because its contents directly drive
  // stalls; a stale count after reset would freeze the pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '{default: '0};
      mdu_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      cnt_q     <= cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench: directed vector table, reset/flush sequences, and
// randomized stimulus compared against a ready-time reference model.
module tb_scoreboard_hazard_unit;

  localparam int REG_AW     = 5;
  localparam int LAT_W      = 3;
  localparam int MDU_CYCLES = 4;
  localparam int NREG       = 1 << REG_AW;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.REG_AW(REG_AW), .LAT_W(LAT_W)) hz ();

  scoreboard_hazard_unit #(
    .REG_AW(REG_AW), .LAT_W(LAT_W), .MDU_CYCLES(MDU_CYCLES)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .hz    (hz)
  );

  typedef struct {
    logic [4:0]  rs, rt;
    logic        use_rs, use_rt, br, rw;
    logic [4:0]  wr;
    logic [2:0]  lat;
    logic        mdu, flush;
    logic        stall, stall_e, flush_d, flush_e, flush_m, busy;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rs, int rt, int urs, int urt, int br, int rw, int wr, int lat,
                              int mdu, int fl, int st, int ste, int fd, int fe, int fm, int busy,
                              logic [31:0] pend);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.use_rs = urs[0]; v.use_rt = urt[0]; v.br = br[0];
    v.rw = rw[0]; v.wr = 5'(wr); v.lat = 3'(lat); v.mdu = mdu[0]; v.flush = fl[0];
    v.stall = st[0]; v.stall_e = ste[0]; v.flush_d = fd[0]; v.flush_e = fe[0];
    v.flush_m = fm[0]; v.busy = busy[0]; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.rsD = v.rs; hz.rtD = v.rt; hz.useRsD = v.use_rs; hz.useRtD = v.use_rt;
    hz.branchD = v.br; hz.regwriteD = v.rw; hz.writeregD = v.wr; hz.latD = v.lat;
    hz.mduD = v.mdu; hz.flush_req = v.flush;
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    check({tag, " stallF"},   hz.stallF,   e.stall);
    check({tag, " stallD"},   hz.stallD,   e.stall);
    check({tag, " stallE"},   hz.stallE,   e.stall_e);
    check({tag, " flushD"},   hz.flushD,   e.flush_d);
    check({tag, " flushE"},   hz.flushE,   e.flush_e);
    check({tag, " flushM"},   hz.flushM,   e.flush_m);
    check({tag, " mdu_busy"}, hz.mdu_busy, e.busy);
    check({tag, " pending"},  hz.pending,  e.pend);
  endtask

  // Reference model: each register has an absolute ready time on a clock that
  // only advances when E is not frozen by the MDU.
  int ptime;
  int ready_at [NREG];
  int mdu_left;

  function automatic int rem(int r);
    if (r == 0) return 0;
    return (ready_at[r] > ptime) ? ready_at[r] - ptime : 0;
  endfunction

  function automatic bit ok(int r, bit u, bit br);
    if (!u || r == 0) return 1;
    return br ? (rem(r) == 0) : (rem(r) <= 1);
  endfunction

  function automatic bit model_ds(vec_t v);
    return !(ok(int'(v.rs), v.use_rs, v.br) && ok(int'(v.rt), v.use_rt, v.br));
  endfunction

  task automatic model_reset();
    ptime = 0; mdu_left = 0;
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
  endtask

  task automatic model_expect(inout vec_t v);
    bit ds, ms;
    ds = model_ds(v);
    ms = (mdu_left > 0);
    v.stall   = v.flush ? 1'b0 : (ds || ms);
    v.stall_e = v.flush ? 1'b0 : ms;
    v.flush_d = v.flush;
    v.flush_e = v.flush ? 1'b1 : (ds && !ms);
    v.flush_m = v.flush ? 1'b1 : ms;
    v.busy    = ms;
    v.pend    = '0;
    for (int r = 1; r < NREG; r++) v.pend[r] = (rem(r) > 0);
  endtask

  task automatic model_step(input vec_t v);
    bit ds, ms, iss;
    ds  = model_ds(v);
    ms  = (mdu_left > 0);
    iss = !v.flush && !(ds || ms);
    if (v.flush) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      ptime = 0; mdu_left = 0;
    end else if (ms) begin
      mdu_left--;
    end else begin
      ptime++;
      if (iss && v.rw && v.wr != 0 && v.lat != 0) ready_at[v.wr] = ptime + int'(v.lat);
      if (iss && v.mdu) mdu_left = MDU_CYCLES - 1;
    end
  endtask

  initial begin
    vec_t nop, v;
    nop = mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 32'h0);

    // rs rt urs urt br | rw wr lat | mdu fl | stall stE flD flE flM busy | pending
    vecs.push_back(mk(0,0,0,0,0, 1,3,1, 0,0, 0,0,0,0,0,0, 32'h0));    // add r3
    vecs.push_back(mk(3,0,1,0,0, 1,6,1, 0,0, 0,0,0,0,0,0, 32'h8));    // add uses r3
    vecs.push_back(mk(6,0,1,0,1, 0,0,0, 0,0, 1,0,0,1,0,0, 32'h40));   // beq r6 stalls
    vecs.push_back(mk(6,0,1,0,1, 0,0,0, 0,0, 0,0,0,0,0,0, 32'h0));
    vecs.push_back(mk(1,0,1,0,0, 1,5,2, 0,0, 0,0,0,0,0,0, 32'h0));    // lw r5
    vecs.push_back(mk(0,5,0,1,0, 1,8,1, 0,0, 1,0,0,1,0,0, 32'h20));   // load-use
    vecs.push_back(mk(0,5,0,1,0, 1,8,1, 0,0, 0,0,0,0,0,0, 32'h20));
    vecs.push_back(mk(0,0,0,0,0, 1,5,2, 0,0, 0,0,0,0,0,0, 32'h100));  // lw r5 again
    vecs.push_back(mk(5,0,1,0,1, 0,0,0, 0,0, 1,0,0,1,0,0, 32'h20));   // beq after load
    vecs.push_back(mk(5,0,1,0,1, 0,0,0, 0,0, 1,0,0,1,0,0, 32'h20));
    vecs.push_back(mk(5,0,1,0,1, 0,0,0, 0,0, 0,0,0,0,0,0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,2, 0,0, 0,0,0,0,0,0, 32'h0));    // write r0
    vecs.push_back(mk(0,0,1,1,1, 0,0,0, 0,0, 0,0,0,0,0,0, 32'h0));    // read r0
    vecs.push_back(mk(0,0,0,0,0, 1,4,2, 0,0, 0,0,0,0,0,0, 32'h0));    // lw r4
    vecs.push_back(mk(1,2,1,1,0, 1,4,1, 0,0, 0,0,0,0,0,0, 32'h10));   // alu r4 overwrite
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 32'h10));   // cnt4 = 1
    vecs.push_back(mk(0,0,0,0,0, 1,9,2, 0,0, 0,0,0,0,0,0, 32'h0));    // cnt4 = 0, lw r9
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,0, 0,0,0,0,0,0, 32'h200));  // div
    vecs.push_back(mk(9,0,1,0,1, 0,0,0, 0,0, 1,1,0,0,1,1, 32'h200));  // mdu + data stall
    vecs.push_back(mk(9,0,1,0,1, 0,0,0, 0,0, 1,1,0,0,1,1, 32'h200));
    vecs.push_back(mk(9,0,1,0,1, 0,0,0, 0,0, 1,1,0,0,1,1, 32'h200));
    vecs.push_back(mk(9,0,1,0,1, 0,0,0, 0,0, 1,0,0,1,0,0, 32'h200));  // frozen count resumes
    vecs.push_back(mk(9,0,1,0,1, 0,0,0, 0,0, 0,0,0,0,0,0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0, 1,7,2, 0,0, 0,0,0,0,0,0, 32'h0));    // lw r7
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,0, 0,0,0,0,0,0, 32'h80));   // div
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0, 1,1,0,0,1,1, 32'h80));
    vecs.push_back(mk(0,0,0,0,0, 1,11,2,1,1, 0,0,1,1,1,1, 32'h80));   // flush + issue
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 32'h0));

    resetn = 1'b0;
    drive(nop);
    repeat (2) @(posedge clk);
    #1 check_outs("reset", nop);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of an MDU count.
    drive(mk(0,0,0,0,0, 0,0,0, 1,0, 0,0,0,0,0,0, 32'h0));
    @(posedge clk); #1;
    drive(mk(0,0,0,0,0, 1,12,2, 0,0, 0,0,0,0,0,0, 32'h0));
    @(negedge clk);
    check("midreset busy_before", hz.mdu_busy, 1'b1);
    check("midreset stallE_before", hz.stallE, 1'b1);
    #1 resetn = 1'b0;
    drive(nop);
    #1 check_outs("midreset", nop);
    @(posedge clk); #1 resetn = 1'b1;

    // Randomized phase against the reference model.
    model_reset();
    for (int i = 0; i < 800; i++) begin
      v.rs     = 5'($urandom_range(0, 7));
      v.rt     = 5'($urandom_range(0, 7));
      v.use_rs = 1'($urandom_range(0, 1));
      v.use_rt = 1'($urandom_range(0, 1));
      v.br     = ($urandom_range(0, 3) == 0);
      v.rw     = 1'($urandom_range(0, 1));
      v.wr     = 5'($urandom_range(0, 7));
      v.lat    = 3'($urandom_range(0, 3));
      v.mdu    = ($urandom_range(0, 14) == 0);
      v.flush  = ($urandom_range(0, 24) == 0);
      drive(v);
      model_expect(v);
      @(negedge clk);
      check_outs($sformatf("rand%0d", i), v);
      @(posedge clk);
      model_step(v);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
# scoreboard_hazard_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core. It replaces fixed stage-compare stall logic with a per-register countdown scoreboard, so producers can declare any result latency. It adds an internal multi-cycle MDU occupancy counter and an exception flush path. It sits beside the datapath and drives all stall and flush enables. Forwarding-mux selection stays in the datapath.

## Interface
- `REG_AW`, default 5: register address width; the scoreboard has 2^REG_AW entries, and entry 0 is never tracked.
- `LAT_W`, default 3: width of the per-register latency countdown.
- `MDU_CYCLES`, default 32: total cycles an MDU op occupies E; must be ≥1.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `rsD`, `rtD` in REG_AW: source registers of the instruction in D.
- `useRsD`, `useRtD` in 1: the D instruction actually reads rs / rt.
- `branchD` in 1: the D instruction consumes its operands in D (branch/jr).
- `regwriteD` in 1: the D instruction writes `writeregD`.
- `writeregD` in REG_AW: destination register.
- `latD` in LAT_W: cycles after issue until the result is forwardable to D; 1 = ALU, 2 = load; 0 = no entry.
- `mduD` in 1: the D instruction is a multi-cycle MDU op.
- `flush_req` in 1: exception/eret taken in M.
- `stallF`, `stallD`, `stallE` out 1: hold PC, IF/ID, ID/EX.
- `flushD`, `flushE`, `flushM` out 1: bubble-insert into IF/ID, ID/EX, EX/MEM.
- `mdu_busy` out 1: the MDU counter is nonzero.
- `pending` out 2^REG_AW: bit r = cnt[r]≠0, for debug/verification.

## Operation
State:
- `cnt[r]` (LAT_W), r = 1..2^REG_AW−1.
- `mdu_cnt`, wide enough for MDU_CYCLES−1.

Combinational:
- `need(r, use)` = use && r≠0.
- Branch consumers need cnt[r]==0; other consumers need cnt[r]≤1 (operand consumed in E one cycle later).
- `datastall` = need(rsD,useRsD) fails its threshold, or need(rtD,useRtD) fails its threshold.
- `mdustall` = mdu_cnt≠0.

Outputs:
- stallF = stallD = datastall || mdustall, when flush_req=0.
- stallE = mdustall, when flush_req=0.
- flushE = datastall && !mdustall. A frozen E is never flushed.
- flushM = mdustall: bubble behind the held MDU op.
- flush_req=1 overrides all of the above: every stall=0 and flushD=flushE=flushM=1.

Issue: the D instruction advances into E when `issue` = !stallD && !flush_req.

Scoreboard update each edge, in priority order:
1. flush_req: all cnt←0, mdu_cnt←0. This aborts the MDU op.
2. mdustall: all cnt hold. E and beyond are frozen, so mdu_cnt←mdu_cnt−1.
3. Otherwise every nonzero cnt decrements by 1. Then, if issue && regwriteD && writeregD≠0 && latD≠0, cnt[writeregD]←latD; a new write overrides the decrement on the same entry. If issue && mduD, mdu_cnt←MDU_CYCLES−1.
- Writes to r0 are ignored; reads of r0 never stall.
- MDU_CYCLES=1 produces no MDU stall.

## Timing
- Reset (resetn=0, asynchronous): all cnt=0, mdu_cnt=0. Consequently all outputs are 0 and pending=0.
- Scoreboard state is registered. All outputs are combinational from state plus D-stage inputs, with no extra latency.
- ALU producer (lat 1):
  - Dependent ALU op: 0 stall cycles.
  - Dependent branch: 1 stall cycle.
- Load producer (lat 2):
  - Dependent ALU op: 1 stall cycle.
  - Dependent branch: 2 stall cycles.
- MDU op entering E at edge t:
  - stallE=1 for cycles t..t+MDU_CYCLES−2.
  - It leaves E at edge t+MDU_CYCLES−1.
- Simultaneous datastall and mdustall: the MDU rules apply, and flushE=0.
- Simultaneous flush_req and issue: no scoreboard entry or MDU count is created.

## Test plan
- Reset/r0:
  - Stimulus: resetn low mid-MDU count, then release.
  - Response: all outputs 0 and pending=0 immediately.
  - Stimulus: writer r0 lat 2, consumer r0.
  - Response: no stall.
- ALU chain:
  - Stimulus: add r3 (lat 1), then add reading r3.
  - Response: 0 stalls.
  - Stimulus: the same but a beq reading r3.
  - Response: stallF=stallD=flushE=1 for exactly 1 cycle.
- Load-use:
  - Stimulus: lw r5 (lat 2), then add using rt=r5.
  - Response: 1 stall/flushE cycle, pending[5] cleared 2 cycles after issue.
  - Stimulus: the same with beq.
  - Response: 2 stall cycles.
- MDU, MDU_CYCLES=4:
  - Stimulus: div issued.
  - Response: stallE=stallD=stallF=flushM=1 for 3 cycles and flushE=0.
  - Stimulus: a pending lat-2 entry during that window.
  - Response: the count freezes at its value.
- Flush:
  - Stimulus: flush_req during MDU stall with pending r7.
  - Response: in that cycle all stalls=0 and flushD/E/M=1; next cycle mdu_busy=0 and pending=0.
- Overwrite:
  - Stimulus: lw r4 (lat 2), then the next issue is an ALU op writing r4 (lat 1) with no dependency on r4.
  - Response: cnt[4]=1 after the second edge and 0 after the third.
